// File: rtl/int_scheduler.sv
// int_scheduler: interrupt factor flags, mask/I gating, fixed-priority
// arbitration and the request/acknowledge/service handshake to the CPU core.
module int_scheduler #(
  parameter int unsigned NUM_SRC  = 6,
  parameter logic [3:0]  VEC_BASE = 4'h2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_event,
  input  logic [NUM_SRC-1:0] factor_clear,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               cpu_int_enable,
  input  logic               int_ack,
  output logic [NUM_SRC-1:0] factor_flags,
  output logic               int_req,
  output logic [3:0]         int_vector,
  output logic               int_busy
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned VEC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   src_sel;
  logic [NUM_SRC-1:0] eligible;
  logic               any_eligible;
  logic [IDX_W-1:0]   winner;
  logic [VEC_W-1:0]   winner_vec;

  assign eligible     = factor_flags & mask;
  assign any_eligible = |eligible;
  assign winner_vec   = VEC_W'(VEC_BASE + VEC_W'({winner, 1'b0}));

  // Priority encoder: highest set index of eligible wins.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i]) winner = IDX_W'(i);
    end
  end

  // Factor flags: set on event, clear on CPU read; set wins a tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      factor_flags <= '0;
    end else begin
      factor_flags <= (factor_flags & ~factor_clear) | src_event;
    end
  end

  // Request/acknowledge/service sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      src_sel    <= '0;
      int_req    <= 1'b0;
      int_vector <= '0;
      int_busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_eligible && cpu_int_enable) begin
            state      <= ST_REQ;
            src_sel    <= winner;
            int_req    <= 1'b1;
            int_vector <= winner_vec;
            int_busy   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            state   <= ST_SERVICE;
            int_req <= 1'b0;
          end else if (!eligible[src_sel] || !cpu_int_enable) begin
            state      <= ST_IDLE;
            int_req    <= 1'b0;
            int_vector <= '0;
            int_busy   <= 1'b0;
          end
        end
        ST_SERVICE: begin
          int_req <= 1'b0;
          if (!cpu_int_enable) begin
            state      <= ST_IDLE;
            int_vector <= '0;
            int_busy   <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          int_req    <= 1'b0;
          int_vector <= '0;
          int_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_scheduler.sv
// Directed testbench for int_scheduler with immediate-assertion checks.
module tb_int_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] src_event;
  logic [5:0] factor_clear;
  logic [5:0] mask;
  logic       cpu_int_enable;
  logic       int_ack;
  logic [5:0] factor_flags;
  logic       int_req;
  logic [3:0] int_vector;
  logic       int_busy;

  int n_cmp = 0;
  int n_err = 0;

  int_scheduler #(.NUM_SRC(6), .VEC_BASE(4'h2)) dut (
    .clk            (clk),
    .reset          (reset),
    .src_event      (src_event),
    .factor_clear   (factor_clear),
    .mask           (mask),
    .cpu_int_enable (cpu_int_enable),
    .int_ack        (int_ack),
    .factor_flags   (factor_flags),
    .int_req        (int_req),
    .int_vector     (int_vector),
    .int_busy       (int_busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic req, input logic [3:0] vec,
                           input logic busy);
    check({tag, ".req"},  8'(int_req),    8'(req));
    check({tag, ".vec"},  8'(int_vector), 8'(vec));
    check({tag, ".busy"}, 8'(int_busy),   8'(busy));
  endtask

  initial begin
    reset = 1'b1; src_event = '0; factor_clear = '0; mask = '0;
    cpu_int_enable = 1'b0; int_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst.flags", 8'(factor_flags), 8'h00);
    check_out("rst", 1'b0, 4'h0, 1'b0);

    // Single source 5
    mask = 6'h20; cpu_int_enable = 1'b1;
    src_event = 6'h20; tick(); src_event = '0;
    check("s1.flags", 8'(factor_flags), 8'h20);
    check("s1.req_n1", 8'(int_req), 8'h0);
    tick();
    check_out("s1.req", 1'b1, 4'hC, 1'b1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check_out("s1.svc", 1'b0, 4'hC, 1'b1);
    tick();
    check_out("s1.svc_hold", 1'b0, 4'hC, 1'b1);
    cpu_int_enable = 1'b0; tick();
    check_out("s1.idle", 1'b0, 4'h0, 1'b0);
    check("s1.flag_kept", 8'(factor_flags), 8'h20);
    factor_clear = 6'h20; tick(); factor_clear = '0;
    check("s1.flag_clr", 8'(factor_flags), 8'h00);

    // Priority: sources 0 and 3 together
    mask = 6'h3F; cpu_int_enable = 1'b1;
    src_event = 6'h09; tick(); src_event = '0;
    check("pr.flags", 8'(factor_flags), 8'h09);
    tick();
    check_out("pr.req3", 1'b1, 4'h8, 1'b1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    cpu_int_enable = 1'b0; tick();
    check_out("pr.idle", 1'b0, 4'h0, 1'b0);
    factor_clear = 6'h08; tick(); factor_clear = '0;
    check("pr.flags2", 8'(factor_flags), 8'h01);
    cpu_int_enable = 1'b1; tick();
    check_out("pr.req0", 1'b1, 4'h2, 1'b1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    cpu_int_enable = 1'b0; tick();
    factor_clear = 6'h01; tick(); factor_clear = '0;
    check("pr.flags3", 8'(factor_flags), 8'h00);

    // Frozen vector while in REQ
    cpu_int_enable = 1'b1;
    src_event = 6'h02; tick(); src_event = '0;
    tick();
    check_out("fz.req1", 1'b1, 4'h4, 1'b1);
    src_event = 6'h20; tick(); src_event = '0;
    check("fz.flags", 8'(factor_flags), 8'h22);
    check_out("fz.frozen_a", 1'b1, 4'h4, 1'b1);
    tick();
    check_out("fz.frozen_b", 1'b1, 4'h4, 1'b1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check_out("fz.svc", 1'b0, 4'h4, 1'b1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check_out("fz.ack_ignored", 1'b0, 4'h4, 1'b1);
    cpu_int_enable = 1'b0; tick();
    check_out("fz.idle", 1'b0, 4'h0, 1'b0);
    cpu_int_enable = 1'b1; tick();
    check_out("fz.req5", 1'b1, 4'hC, 1'b1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    cpu_int_enable = 1'b0; tick();
    factor_clear = 6'h22; tick(); factor_clear = '0;
    check("fz.flags_clr", 8'(factor_flags), 8'h00);

    // Withdraw on source 2; set+clear tie keeps the flag
    cpu_int_enable = 1'b1;
    src_event = 6'h04; tick(); src_event = '0;
    tick();
    check_out("wd.req2", 1'b1, 4'h6, 1'b1);
    src_event = 6'h04; factor_clear = 6'h04; tick();
    src_event = '0; factor_clear = '0;
    check("wd.tie_flag", 8'(factor_flags), 8'h04);
    tick();
    check_out("wd.no_withdraw", 1'b1, 4'h6, 1'b1);
    factor_clear = 6'h04; tick(); factor_clear = '0;
    check("wd.flag_clr", 8'(factor_flags), 8'h00);
    tick();
    check_out("wd.withdrawn", 1'b0, 4'h0, 1'b0);

    // Mask and I gating
    mask = 6'h00; cpu_int_enable = 1'b1;
    src_event = 6'h3F; tick(); src_event = '0;
    check("gt.flags", 8'(factor_flags), 8'h3F);
    tick(); tick();
    check_out("gt.masked", 1'b0, 4'h0, 1'b0);
    mask = 6'h3F; cpu_int_enable = 1'b0;
    tick(); tick();
    check_out("gt.i_off", 1'b0, 4'h0, 1'b0);
    cpu_int_enable = 1'b1; tick();
    check_out("gt.req", 1'b1, 4'hC, 1'b1);

    // Reset while in REQ, with a simultaneous ack
    reset = 1'b1; int_ack = 1'b1; tick();
    reset = 1'b0; int_ack = 1'b0;
    check("rr.flags", 8'(factor_flags), 8'h00);
    check_out("rr", 1'b0, 4'h0, 1'b0);
    tick();
    check_out("rr.after", 1'b0, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
